// File: rtl/string_hw.sv
// String coprocessor: compare, to-upper, to-lower, one character per clock.
// Defining STRING_HW_REVERSE_EN adds index 3 = reverse(A).
module string_hw #(
  parameter int MAX_LEN = 2,
  parameter int LEN_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic [2:0]           index,
  input  logic [MAX_LEN*8-1:0] A,
  input  logic [MAX_LEN*8-1:0] B,
  input  logic [LEN_W-1:0]     lengthA,
  input  logic [LEN_W-1:0]     lengthB,
  output logic                 done,
  output logic [MAX_LEN*8-1:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                state_reg;
  logic [2:0]                index_reg;
  logic [0:MAX_LEN-1][7:0]   a_reg, b_reg, result_reg;
  logic [LEN_W-1:0]          len_a_reg, i_reg;
  logic                      eq_reg, done_reg;

  logic [7:0]                a_char, b_char, char_next;
  logic                      in_range, mismatch, eq_next;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (int'(len) > MAX_LEN) return LEN_W'(MAX_LEN);
    return len;
  endfunction

  // Explicit muxes keep the counter width independent of the array depth.
  always_comb begin
    a_char = 8'h00;
    b_char = 8'h00;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (i_reg == LEN_W'(k)) begin
        a_char = a_reg[k];
        b_char = b_reg[k];
      end
    end
  end

`ifdef STRING_HW_REVERSE_EN
  logic [LEN_W-1:0] rev_idx;
  logic [7:0]       rev_char;
  assign rev_idx = len_a_reg - i_reg - LEN_W'(1);
  always_comb begin
    rev_char = 8'h00;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (rev_idx == LEN_W'(k)) rev_char = a_reg[k];
    end
  end
`endif

  assign in_range = (i_reg < len_a_reg);
  assign mismatch = in_range && (a_char != b_char);
  assign eq_next  = eq_reg & ~mismatch;

  always_comb begin
    char_next = 8'h00;
    if (in_range) begin
      case (index_reg)
        3'd1: char_next = (a_char inside {[8'h61:8'h7a]}) ? a_char - 8'h20 : a_char;
        3'd2: char_next = (a_char inside {[8'h41:8'h5a]}) ? a_char + 8'h20 : a_char;
`ifdef STRING_HW_REVERSE_EN
        3'd3: char_next = rev_char;
`endif
        default: char_next = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      index_reg  <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      len_a_reg  <= '0;
      i_reg      <= '0;
      eq_reg     <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (go) begin
            index_reg  <= index;
            a_reg      <= A;
            b_reg      <= B;
            len_a_reg  <= clamp_len(lengthA);
            eq_reg     <= (clamp_len(lengthA) == clamp_len(lengthB));
            result_reg <= '0;
            i_reg      <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < MAX_LEN; k++) begin
            if (i_reg == LEN_W'(k)) result_reg[k] <= char_next;
          end
          eq_reg <= eq_next;
          i_reg  <= i_reg + LEN_W'(1);
          if (i_reg == LEN_W'(MAX_LEN - 1)) begin
            state_reg <= DONE;
            // Compare verdict lands in the LSB of the last byte.
            if (index_reg == 3'd0) result_reg[MAX_LEN-1][0] <= eq_next;
          end
        end
        DONE: begin
          done_reg <= go;
          if (!go) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_string_hw.sv
// Scoreboard bench for string_hw: driver queues expected results, monitor checks on done.
module tb_string_hw;
  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [2:0]  index;
  logic [15:0] A, B;
  logic [1:0]  lengthA, lengthB;
  logic        done;
  logic [15:0] result;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb_q[$];
  string       name_q[$];
  logic        done_q = 1'b0;

  string_hw #(.MAX_LEN(2), .LEN_W(2)) dut (
    .clk(clk), .reset(reset), .go(go), .index(index), .A(A), .B(B),
    .lengthA(lengthA), .lengthB(lengthB), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expectation per rising done.
  initial begin
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: result=%h with no pending op", result);
        end else begin
          logic [15:0] exp;
          string nm;
          exp = sb_q.pop_front();
          nm  = name_q.pop_front();
          if (result !== exp) begin
            bad++;
            $display("FAIL %s: result=%h required %h", nm, result, exp);
          end else
            $display("ok %s: result=%h", nm, result);
        end
      end
      done_q = done;
    end
  end

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] idx, input logic [15:0] a,
                        input logic [15:0] b, input logic [1:0] la, input logic [1:0] lb,
                        input logic [15:0] exp, input int hold);
    int cyc;
    sb_q.push_back(exp);
    name_q.push_back(nm);
    @(negedge clk);
    index = idx; A = a; B = b; lengthA = la; lengthB = lb; go = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        // Operand changes while busy must be ignored.
        A = ~a; B = ~b; index = ~idx; lengthA = ~la; lengthB = ~lb;
      end
    end while (!done && cyc < 20);
    check({nm, "_latency"}, 16'(cyc), 16'd4);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({nm, "_hold_done"}, {15'd0, done}, 16'd1);
      check({nm, "_hold_result"}, result, exp);
    end
    go = 1'b0;
    @(negedge clk);
    check({nm, "_done_drop"}, {15'd0, done}, 16'd0);
  endtask

  initial begin
    logic [15:0] rev_exp;
`ifdef STRING_HW_REVERSE_EN
    rev_exp = 16'h6261;
`else
    rev_exp = 16'h0000;
`endif
    reset = 1'b0; go = 1'b0; index = '0; A = '0; B = '0; lengthA = '0; lengthB = '0;
    #12;
    check("reset_done", {15'd0, done}, 16'd0);
    check("reset_result", result, 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    run_op("cmp_ab_ac",    3'd0, 16'h6162, 16'h6163, 2'd2, 2'd2, 16'h0000, 0);
    run_op("cmp_ab_ab",    3'd0, 16'h6162, 16'h6162, 2'd2, 2'd2, 16'h0001, 0);
    run_op("cmp_lenb1",    3'd0, 16'h6162, 16'h6162, 2'd2, 2'd1, 16'h0000, 0);
    run_op("cmp_case",     3'd0, 16'h6162, 16'h4142, 2'd2, 2'd2, 16'h0000, 0);
    run_op("cmp_empty",    3'd0, 16'h1234, 16'h5678, 2'd0, 2'd0, 16'h0001, 0);
    run_op("up_ab",        3'd1, 16'h6162, 16'h0000, 2'd2, 2'd0, 16'h4142, 0);
    run_op("up_aB",        3'd1, 16'h6142, 16'h0000, 2'd2, 2'd0, 16'h4142, 0);
    run_op("up_a_len1",    3'd1, 16'h6162, 16'h0000, 2'd1, 2'd0, 16'h4100, 0);
    run_op("up_z_brace",   3'd1, 16'h7a7b, 16'h0000, 2'd2, 2'd0, 16'h5a7b, 0);
    run_op("up_len3_clamp",3'd1, 16'h6162, 16'h0000, 2'd3, 2'd0, 16'h4142, 0);
    run_op("up_len0",      3'd1, 16'h6162, 16'h0000, 2'd0, 2'd0, 16'h0000, 0);
    run_op("lo_AB",        3'd2, 16'h4142, 16'h0000, 2'd2, 2'd0, 16'h6162, 0);
    run_op("lo_aB",        3'd2, 16'h6142, 16'h0000, 2'd2, 2'd0, 16'h6162, 0);
    run_op("lo_at_Z",      3'd2, 16'h405a, 16'h0000, 2'd2, 2'd0, 16'h407a, 0);
    run_op("idx5",         3'd5, 16'h6162, 16'h6162, 2'd2, 2'd2, 16'h0000, 0);
    run_op("idx3_rev",     3'd3, 16'h6162, 16'h0000, 2'd2, 2'd0, rev_exp,   0);
    run_op("go_held",      3'd1, 16'h6162, 16'h0000, 2'd2, 2'd0, 16'h4142, 4);

    // Abort mid-op: reset must clear outputs at once and no done follows.
    @(negedge clk);
    index = 3'd1; A = 16'h6162; lengthA = 2'd2; go = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_done", {15'd0, done}, 16'd0);
    check("abort_result", result, 16'h0000);
    go = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", {15'd0, done}, 16'd0);

    check("scoreboard_empty", 16'(sb_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
